dcache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the `cpu` data port and the backing memory bus. It accepts CPU loads and stores and stalls the CPU with `o_valid` low while busy. Read misses fill a whole line over a single-beat request/ack memory handshake. Stores update the line on a hit and are always written through to memory with their byte mask.

---
 rtl/dcache.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a single-beat
// request/ack memory port. Define DCACHE_UNCACHED_EN to make addr[31]=1 uncached.
module dcache #(
   parameter int SETS_LOG2 = 6,
   parameter int LINE_LOG2 = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_addr,
   input  logic        i_rd,
   input  logic [3:0]  i_wr,
   input  logic [31:0] i_data_wr,
   output logic [31:0] o_data_rd,
   output logic        o_valid,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_rd,
   output logic [3:0]  o_mem_wr,
   output logic [31:0] o_mem_data_wr,
   input  logic [31:0] i_mem_data_rd,
   input  logic        i_mem_ack
);
   localparam int SETS   = 1 << SETS_LOG2;
   localparam int WORDS  = 1 << LINE_LOG2;
   localparam int IDX_LO = LINE_LOG2 + 2;
   localparam int TAG_W  = 32 - SETS_LOG2 - LINE_LOG2 - 2;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;

   state_t                 r_state;
   logic [31:2]            r_addr;
   logic [3:0]             r_mask;
   logic [31:0]            r_wdata;
   logic                   r_store;
   logic                   r_hit;
   logic [LINE_LOG2-1:0]   r_beat;
   logic [31:0]            r_resp;
   logic [SETS-1:0]        r_vld;
   logic [TAG_W-1:0]       r_tag [SETS];
   logic [31:0]            r_mem [SETS*WORDS];

   logic [SETS_LOG2-1:0]   w_idx_in, w_idx;
   logic [LINE_LOG2-1:0]   w_off_in, w_off, w_beat_nx;
   logic [TAG_W-1:0]       w_tag_in, w_tag;
   logic                   w_unc_in, w_unc, w_hit_in, w_last, w_take;
   logic [31:0]            w_merge;
   logic                   w_unused;

   assign w_unused  = ^i_addr[1:0];
   assign w_idx_in  = i_addr[IDX_LO +: SETS_LOG2];
   assign w_off_in  = i_addr[2 +: LINE_LOG2];
   assign w_tag_in  = i_addr[31 -: TAG_W];
   assign w_idx     = r_addr[IDX_LO +: SETS_LOG2];
   assign w_off     = r_addr[2 +: LINE_LOG2];
   assign w_tag     = r_addr[31 -: TAG_W];
   assign w_beat_nx = r_beat + LINE_LOG2'(1);

`ifdef DCACHE_UNCACHED_EN
   assign w_unc_in = i_addr[31];
   assign w_unc    = r_addr[31];
`else
   assign w_unc_in = 1'b0;
   assign w_unc    = 1'b0;
`endif

   // Hit is resolved as the request is sampled so a load hit can complete in LOOKUP
   assign w_hit_in = r_vld[w_idx_in] && (r_tag[w_idx_in] == w_tag_in) && !w_unc_in;
   assign w_last   = w_unc || (&r_beat);
   assign w_take   = w_unc || (r_beat == w_off);

   always_comb begin
      w_merge = r_mem[{w_idx, w_off}];
      for (int b = 0; b < 4; b++)
         if (r_mask[b]) w_merge[8*b +: 8] = r_wdata[8*b +: 8];
   end

   always_ff @(posedge i_clk) begin
      if (r_state == LOOKUP && r_store && r_hit)
         r_mem[{w_idx, w_off}] <= w_merge;
      if (r_state == FILL && i_mem_ack && !w_unc) begin
         r_mem[{w_idx, r_beat}] <= i_mem_data_rd;
         if (&r_beat) r_tag[w_idx] <= w_tag;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_mask        <= '0;
         r_wdata       <= '0;
         r_store       <= 1'b0;
         r_hit         <= 1'b0;
         r_beat        <= '0;
         r_resp        <= '0;
         r_vld         <= '0;
         o_valid       <= 1'b0;
         o_data_rd     <= '0;
         o_mem_addr    <= '0;
         o_mem_rd      <= 1'b0;
         o_mem_wr      <= '0;
         o_mem_data_wr <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_rd || |i_wr) begin
               r_addr  <= i_addr[31:2];
               r_mask  <= i_wr;
               r_wdata <= i_data_wr;
               r_store <= |i_wr;
               r_hit   <= w_hit_in;
               if (!(|i_wr) && w_hit_in) begin
                  o_valid   <= 1'b1;
                  o_data_rd <= r_mem[{w_idx_in, w_off_in}];
               end
               r_state <= LOOKUP;
            end
            LOOKUP: if (r_store) begin
               o_mem_wr      <= r_mask;
               o_mem_addr    <= {r_addr, 2'b00};
               o_mem_data_wr <= r_wdata;
               r_state       <= WRITE;
            end else if (r_hit) begin
               o_valid   <= 1'b0;
               o_data_rd <= '0;
               r_state   <= IDLE;
            end else begin
               // Invalidate up front so an interrupted fill never leaves a half line valid
               if (!w_unc) r_vld[w_idx] <= 1'b0;
               r_beat     <= '0;
               o_mem_rd   <= 1'b1;
               o_mem_addr <= w_unc ? {r_addr, 2'b00}
                                   : {r_addr[31:IDX_LO], {LINE_LOG2{1'b0}}, 2'b00};
               r_state    <= FILL;
            end
            FILL: if (i_mem_ack) begin
               if (w_take) r_resp <= i_mem_data_rd;
               r_beat <= w_beat_nx;
               if (w_last) begin
                  if (!w_unc) r_vld[w_idx] <= 1'b1;
                  o_mem_rd   <= 1'b0;
                  o_mem_addr <= '0;
                  o_valid    <= 1'b1;
                  o_data_rd  <= w_take ? i_mem_data_rd : r_resp;
                  r_state    <= RESP;
               end else begin
                  o_mem_addr <= {r_addr[31:IDX_LO], w_beat_nx, 2'b00};
               end
            end
            WRITE: if (i_mem_ack) begin
               o_mem_wr      <= '0;
               o_mem_addr    <= '0;
               o_mem_data_wr <= '0;
               o_valid       <= 1'b1;
               r_state       <= RESP;
            end
            RESP: begin
               o_valid   <= 1'b0;
               o_data_rd <= '0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
